node_pkt_tx: RTL and testbench
==============================

# node_pkt_tx

Outgoing packet builder for an EER-RL sensor node: the transmit-side counterpart of the node's packet-intake and node-info logic. On a one-cycle `start` it snapshots the node's state (ID, hops, Q-value, energy, cluster-head fields), then emits the requested packet as a stream of 16-bit words over a valid/ready interface toward the radio/TX buffer. It covers heartbeat rebroadcast (HB), cluster-head invitation (INV) and member join (JOIN), and rejects any packet the node's current role does not permit.

## Interface
- No parameters; word width is fixed at 16 (`WORD_WIDTH`).
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: synchronous reset, **active-high**. Keeps the codebase name despite the polarity.
- `start` in 1: one-cycle request to build a packet.
- `txPktType` in 3: requested type. 3'b000 = HB, 3'b010 = INV, 3'b011 = JOIN.
- `myNodeID`, `hopsFromSink`, `myQValue`, `energy` in 16 each: the node's own state.
- `e_max`, `e_min`, `e_threshold` in 16 each: 14.2 fixed-point energy fields relayed in HB.
- `ch_ID`, `timeslot` in 16 each: target cluster head (JOIN) and assigned slot (INV).
- `role` in 1: 1 = cluster head, 0 = member.
- `tx_data` out 16: current word.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts the word.
- `tx_last` out 1: current word is the final word of the packet.
- `busy` out 1: a packet is in progress.
- `done` out 1: one-cycle pulse marking packet completion.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, SEND.
- **IDLE:** on `start`, check the request:
  - Legal requests: HB always; INV only if `role`=1; JOIN only if `role`=0.
  - Illegal request (wrong role or unsupported type): pulse `err` next cycle, stay in IDLE, emit no words.
  - Legal request: load all inputs into snapshot registers, clear word index to 0, go to SEND.
- **Header word:** {type[2:0], 8'h00, nWords[4:0]}. `nWords` includes the header.
- **HB (7 words):** header, myNodeID, hopsFromSink+1, e_max, e_min, energy, e_threshold.
  - hops+1 saturates: 16'hFFFF stays 16'hFFFF.
- **INV (5 words):** header, myNodeID, myQValue, hopsFromSink, timeslot.
- **JOIN (5 words):** header, myNodeID, ch_ID, myQValue, energy.
- **SEND:**
  - `tx_valid`=1. `tx_data` is selected by word index from the snapshot.
  - On `tx_valid && tx_ready`, the index increments.
  - `tx_last`=1 when index = nWords-1.
  - Handshake on the last word → IDLE, with `done` pulsed.
- **Stall:** while `tx_ready`=0, `tx_data`/`tx_last` hold stable. Input changes have no effect (snapshot).
- **`start` during SEND:** ignored; no `err`, no queueing.
- **Reset:** any time, including mid-packet, the next edge forces IDLE and all outputs to 0. The partial packet is abandoned.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `tx_last`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `start` sampled at edge N → `tx_valid`=1 and the header on `tx_data` from cycle N+1.
- `busy`=1 from cycle N+1 through the cycle of the last handshake.
- Throughput: 1 word/cycle with `tx_ready` held high. An HB packet occupies cycles N+1..N+7.
- Last handshake at edge M → `done`=1 and `busy`=0 in cycle M+1.
  - `start` sampled at edge M+1 is accepted, so packets can run back-to-back with a one-cycle gap.
- `err` pulses in cycle N+1 for a rejected request. `busy` stays 0.
- All outputs are registered. There is no combinational path from `tx_ready` to `tx_data`.

## Configuration
- `PKT_CHECKSUM_EN` defined:
  - A trailer word is appended after the last field: XOR of all preceding words, header included.
  - `nWords` counts the trailer (HB 8, INV 6, JOIN 6), and `tx_last` moves to the trailer.
- Undefined: no trailer; lengths are as listed under Operation.

## Structure
- Shared package (`eer_pkt_pkg`) holds:
  - packet-type constants (HB=3'b000, CHE=3'b001, INV=3'b010, JOIN=3'b011);
  - per-type word counts;
  - header field positions;
  - `WORD_WIDTH`.
  - The node-info block uses the same type constants.
- One sub-module, `pkt_word_mux`: combinational field select from snapshot + type + index, producing the next `tx_data` value.
- Index counter, FSM and checksum accumulator stay in `node_pkt_tx`.

## Test plan
- Node state used below: myNodeID=000C, hops=1, e_max=8000, e_min=4000, energy=8000, e_threshold=3333, `tx_ready`=1.
- HB with the node state above → 0007, 000C, 0002, 8000, 4000, 8000, 3333; `tx_last` on the 7th word; `done` the cycle after.
- INV, role=1, Q=1234, timeslot=0003 → 4005, 000C, 1234, 0001, 0003. Same request with role=0 → `err` pulse, `tx_valid` stays 0.
- JOIN, role=0, ch_ID=0020, stalls: `tx_ready` low for 3 cycles at word 2 and inputs changed during the stall → words 6005, 000C, 0020, Q, 8000 unchanged; `tx_data` stable throughout the stall.
- hopsFromSink=FFFF, HB → word 2 = FFFF. `start` pulsed mid-packet → ignored, packet intact.
- `nrst` asserted during word 3 of HB → outputs 0 next cycle. A new HB afterwards starts cleanly at the header.
- With `PKT_CHECKSUM_EN`: the HB above → header 0008, 8th word = XOR of the first seven words.

Source files
------------

// File: rtl/eer_pkt_pkg.sv
// Shared packet definitions for the EER-RL node: type codes, word counts, header layout.
// Word counts include a checksum trailer when PKT_CHECKSUM_EN is defined.
package eer_pkt_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_INV  = 3'b010;
    localparam logic [2:0] PKT_JOIN = 3'b011;

`ifdef PKT_CHECKSUM_EN
    localparam logic [4:0] CSUM_WORDS = 5'd1;
`else
    localparam logic [4:0] CSUM_WORDS = 5'd0;
`endif

    localparam logic [4:0] HB_WORDS   = 5'd7 + CSUM_WORDS;
    localparam logic [4:0] INV_WORDS  = 5'd5 + CSUM_WORDS;
    localparam logic [4:0] JOIN_WORDS = 5'd5 + CSUM_WORDS;

    localparam int HDR_TYPE_LSB = 13;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] node_id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] qval;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] e_max;
        logic [WORD_WIDTH-1:0] e_min;
        logic [WORD_WIDTH-1:0] e_thr;
        logic [WORD_WIDTH-1:0] ch_id;
        logic [WORD_WIDTH-1:0] timeslot;
    } node_snap_t;

    function automatic logic [4:0] pkt_words(input logic [2:0] t);
        case (t)
            PKT_HB:   return HB_WORDS;
            PKT_INV:  return INV_WORDS;
            PKT_JOIN: return JOIN_WORDS;
            default:  return 5'd0;
        endcase
    endfunction

    // A cluster head invites, a member joins; anyone may relay a heartbeat.
    function automatic logic pkt_legal(input logic [2:0] t, input logic is_ch);
        case (t)
            PKT_HB:   return 1'b1;
            PKT_INV:  return is_ch;
            PKT_JOIN: return !is_ch;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [WORD_WIDTH-1:0] pkt_header(input logic [2:0] t);
        logic [WORD_WIDTH-1:0] h;
        h = '0;
        h[HDR_TYPE_LSB +: 3]       = t;
        h[HDR_LEN_LSB +: HDR_LEN_W] = pkt_words(t);
        return h;
    endfunction

endpackage

// File: rtl/pkt_word_mux.sv
// Field select for the outgoing packet: returns the word at a given index for a packet type.
// Indices past the last field (e.g. the checksum slot) return zero; the caller fills them.
module pkt_word_mux
    import eer_pkt_pkg::*;
(
    input  node_snap_t            snap_i,
    input  logic [2:0]            type_i,
    input  logic [4:0]            idx_i,
    output logic [WORD_WIDTH-1:0] word_o
);

    logic [WORD_WIDTH-1:0] hops_inc;

    // Hop count relayed in a heartbeat is one further from the sink, saturating.
    assign hops_inc = (snap_i.hops == 16'hFFFF) ? 16'hFFFF : snap_i.hops + 16'd1;

    always_comb begin
        word_o = '0;
        if (idx_i == 5'd0) begin
            word_o = pkt_header(type_i);
        end else begin
            case (type_i)
                PKT_HB: begin
                    case (idx_i)
                        5'd1:    word_o = snap_i.node_id;
                        5'd2:    word_o = hops_inc;
                        5'd3:    word_o = snap_i.e_max;
                        5'd4:    word_o = snap_i.e_min;
                        5'd5:    word_o = snap_i.energy;
                        5'd6:    word_o = snap_i.e_thr;
                        default: word_o = '0;
                    endcase
                end
                PKT_INV: begin
                    case (idx_i)
                        5'd1:    word_o = snap_i.node_id;
                        5'd2:    word_o = snap_i.qval;
                        5'd3:    word_o = snap_i.hops;
                        5'd4:    word_o = snap_i.timeslot;
                        default: word_o = '0;
                    endcase
                end
                PKT_JOIN: begin
                    case (idx_i)
                        5'd1:    word_o = snap_i.node_id;
                        5'd2:    word_o = snap_i.ch_id;
                        5'd3:    word_o = snap_i.qval;
                        5'd4:    word_o = snap_i.energy;
                        default: word_o = '0;
                    endcase
                end
                default: word_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/node_pkt_tx.sv
// Outgoing packet builder (HB / INV / JOIN) streaming 16-bit words over valid/ready.
// Define PKT_CHECKSUM_EN to append an XOR trailer word to every packet.
module node_pkt_tx
    import eer_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [2:0]  txPktType,
    input  logic [15:0] myNodeID,
    input  logic [15:0] hopsFromSink,
    input  logic [15:0] myQValue,
    input  logic [15:0] energy,
    input  logic [15:0] e_max,
    input  logic [15:0] e_min,
    input  logic [15:0] e_threshold,
    input  logic [15:0] ch_ID,
    input  logic [15:0] timeslot,
    input  logic        role,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
    // tx_data/tx_last are held while tx_valid is high and tx_ready is low.

    tx_state_e             state_q;
    node_snap_t            snap_q;
    node_snap_t            live_snap;
    node_snap_t            mux_snap;
    logic [2:0]            type_q;
    logic [2:0]            mux_type;
    logic [4:0]            idx_q;
    logic [4:0]            idx_d;
    logic [4:0]            nwords_d;
    logic                  last_d;
    logic [WORD_WIDTH-1:0] mux_word;
    logic [WORD_WIDTH-1:0] word_d;
    logic [WORD_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  tx_last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
`ifdef PKT_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum_q;
`endif

    assign live_snap = '{node_id:  myNodeID,     hops:  hopsFromSink, qval:  myQValue,
                         energy:   energy,       e_max: e_max,        e_min: e_min,
                         e_thr:    e_threshold,  ch_id: ch_ID,        timeslot: timeslot};

    // In IDLE the header is built from live inputs so it is on the bus the cycle after start.
    assign mux_snap = (state_q == ST_IDLE) ? live_snap : snap_q;
    assign mux_type = (state_q == ST_IDLE) ? txPktType : type_q;
    assign idx_d    = (state_q == ST_IDLE) ? 5'd0 : idx_q + 5'd1;
    assign nwords_d = pkt_words(mux_type);
    assign last_d   = (idx_d == nwords_d - 5'd1);

    pkt_word_mux u_word_mux (
        .snap_i (mux_snap),
        .type_i (mux_type),
        .idx_i  (idx_d),
        .word_o (mux_word)
    );

`ifdef PKT_CHECKSUM_EN
    assign word_d = last_d ? csum_q : mux_word;
`else
    assign word_d = mux_word;
`endif

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            type_q     <= PKT_HB;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (pkt_legal(txPktType, role)) begin
                            state_q    <= ST_SEND;
                            snap_q     <= live_snap;
                            type_q     <= txPktType;
                            idx_q      <= idx_d;
                            tx_data_q  <= word_d;
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= last_d;
                            busy_q     <= 1'b1;
`ifdef PKT_CHECKSUM_EN
                            csum_q     <= word_d;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // tx_valid is always high here, so tx_ready alone marks a handshake.
                    if (tx_ready) begin
                        if (tx_last_q) begin
                            state_q    <= ST_IDLE;
                            tx_data_q  <= '0;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= word_d;
                            tx_last_q <= last_d;
`ifdef PKT_CHECKSUM_EN
                            csum_q    <= csum_q ^ word_d;
`endif
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_node_pkt_tx.sv
// Self-checking bench for node_pkt_tx: directed scenarios plus randomized packets with
// random back-pressure, checked against a packet-level reference model.
module tb_node_pkt_tx;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [2:0]  txPktType;
    logic [15:0] myNodeID, hopsFromSink, myQValue, energy;
    logic [15:0] e_max, e_min, e_threshold, ch_ID, timeslot;
    logic        role;
    logic [15:0] tx_data;
    logic        tx_valid, tx_ready, tx_last, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    // Node state the model and driver agree on.
    logic [2:0]  m_type;
    logic [15:0] m_id, m_hops, m_q, m_energy, m_emax, m_emin, m_ethr, m_ch, m_ts;
    logic        m_role;

    always #5 clk = ~clk;

    node_pkt_tx dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .txPktType    (txPktType),
        .myNodeID     (myNodeID),
        .hopsFromSink (hopsFromSink),
        .myQValue     (myQValue),
        .energy       (energy),
        .e_max        (e_max),
        .e_min        (e_min),
        .e_threshold  (e_threshold),
        .ch_ID        (ch_ID),
        .timeslot     (timeslot),
        .role         (role),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic apply_state();
        txPktType    = m_type;
        myNodeID     = m_id;
        hopsFromSink = m_hops;
        myQValue     = m_q;
        energy       = m_energy;
        e_max        = m_emax;
        e_min        = m_emin;
        e_threshold  = m_ethr;
        ch_ID        = m_ch;
        timeslot     = m_ts;
        role         = m_role;
    endtask

    task automatic scramble_inputs();
        txPktType    = 3'($urandom_range(0, 7));
        myNodeID     = 16'($urandom);
        hopsFromSink = 16'($urandom);
        myQValue     = 16'($urandom);
        energy       = 16'($urandom);
        e_max        = 16'($urandom);
        e_min        = 16'($urandom);
        e_threshold  = 16'($urandom);
        ch_ID        = 16'($urandom);
        timeslot     = 16'($urandom);
        role         = 1'($urandom_range(0, 1));
    endtask

    task automatic set_default_node();
        m_id = 16'h000C; m_hops = 16'h0001; m_emax = 16'h8000; m_emin = 16'h4000;
        m_energy = 16'h8000; m_ethr = 16'h3333; m_q = 16'h1234; m_ts = 16'h0003;
        m_ch = 16'h0020;
    endtask

    function automatic bit model_legal(input logic [2:0] t, input logic r);
        return (t == 3'd0) || (t == 3'd2 && r) || (t == 3'd3 && !r);
    endfunction

    // Reference packet: header, type-specific fields, optional XOR trailer.
    function automatic void build_expected();
        logic [15:0] f[$];
        logic [15:0] hdr;
        logic [15:0] x;
        int hop_sum;
        int n;
        exp_q.delete();
        hop_sum = int'(m_hops) + 1;
        if (hop_sum > 65535) hop_sum = 65535;
        case (m_type)
            3'd0: begin
                f.push_back(m_id); f.push_back(16'(hop_sum)); f.push_back(m_emax);
                f.push_back(m_emin); f.push_back(m_energy); f.push_back(m_ethr);
            end
            3'd2: begin
                f.push_back(m_id); f.push_back(m_q); f.push_back(m_hops); f.push_back(m_ts);
            end
            default: begin
                f.push_back(m_id); f.push_back(m_ch); f.push_back(m_q); f.push_back(m_energy);
            end
        endcase
        n = f.size() + 1;
`ifdef PKT_CHECKSUM_EN
        n = n + 1;
`endif
        hdr = {m_type, 8'h00, 5'(n)};
        exp_q.push_back(hdr);
        foreach (f[i]) exp_q.push_back(f[i]);
`ifdef PKT_CHECKSUM_EN
        x = 16'h0000;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 16'h0000;
`endif
    endfunction

    // Starts a packet from the model state and checks every word through completion.
    // Leaves the bench at the negedge of the cycle where done is expected.
    task automatic send_and_check(input string name, input int stall_at, input int stall_pct,
                                  input bit noise);
        int widx;
        int cyc;
        int stall_cnt;
        bit rdy;
        build_expected();
        apply_state();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b, expected 1", name, busy);
        end
        widx = 0; cyc = 0; stall_cnt = 0;
        while (widx < exp_q.size() && cyc < 400) begin
            if (widx == stall_at && stall_cnt < 3) begin
                rdy = 1'b0;
                stall_cnt++;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
            tx_ready = rdy;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[widx]) begin
                errors++;
                $display("FAIL %s word%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         name, widx, tx_valid, tx_data, exp_q[widx]);
            end
            checks++;
            if (tx_last !== (widx == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL %s last@word%0d: got %b, expected %b", name, widx, tx_last,
                         (widx == exp_q.size() - 1));
            end
            checks++;
            if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s flags@word%0d: got busy=%b err=%b done=%b, expected 1 0 0",
                         name, widx, busy, err, done);
            end
            if (noise) begin
                scramble_inputs();
                start = ($urandom_range(0, 3) == 0);
            end
            if (rdy) widx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        checks++;
        if (widx < exp_q.size()) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, expected %0d", name, widx, exp_q.size());
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s completion: got done=%b busy=%b valid=%b, expected 1 0 0",
                     name, done, busy, tx_valid);
        end
    endtask

    task automatic check_reject(input string name);
        apply_state();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s reject: got err=%b valid=%b busy=%b, expected 1 0 0",
                     name, err, tx_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s reject_after: got err=%b valid=%b, expected 0 0", name, err, tx_valid);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({tx_data, tx_valid, tx_last, busy, done, err} !== 21'd0) begin
            errors++;
            $display("FAIL %s outputs: got data=%h valid=%b last=%b busy=%b done=%b err=%b, expected all 0",
                     name, tx_data, tx_valid, tx_last, busy, done, err);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        set_default_node(); m_type = 3'd0; m_role = 1'b0;
        apply_state();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_held");
        nrst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_released");
    endtask

    task automatic test_hb();
        set_default_node(); m_type = 3'd0; m_role = 1'b0;
        send_and_check("hb", -1, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL hb done_pulse: got %b, expected 0", done);
        end
    endtask

    task automatic test_inv();
        set_default_node(); m_type = 3'd2; m_role = 1'b1;
        send_and_check("inv", -1, 0, 1'b0);
        @(negedge clk);
        m_role = 1'b0;
        check_reject("inv_member");
        m_type = 3'd3; m_role = 1'b1;
        check_reject("join_head");
        m_type = 3'd1; m_role = 1'b1;
        check_reject("che_type");
    endtask

    task automatic test_join_stall();
        set_default_node(); m_type = 3'd3; m_role = 1'b0;
        send_and_check("join_stall", 2, 0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_hops_sat();
        set_default_node(); m_hops = 16'hFFFF; m_type = 3'd0; m_role = 1'b1;
        send_and_check("hb_sat", -1, 0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_default_node(); m_type = 3'd0; m_role = 1'b0;
        build_expected();
        apply_state();
        tx_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_data !== exp_q[3] || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid word3: got valid=%b data=%h, expected 1 %h", tx_valid, tx_data, exp_q[3]);
        end
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        check_outputs_zero("reset_mid");
        send_and_check("hb_after_reset", -1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        set_default_node(); m_role = 1'b1;
        m_type = 3'd0;
        send_and_check("b2b_hb", -1, 0, 1'b0);
        m_type = 3'd2;
        send_and_check("b2b_inv", -1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: m_type = 3'd0;
                1: m_type = 3'd2;
                2: m_type = 3'd3;
                default: m_type = 3'($urandom_range(0, 7));
            endcase
            m_role = 1'($urandom_range(0, 1));
            m_id = 16'($urandom); m_hops = 16'($urandom); m_q = 16'($urandom);
            m_energy = 16'($urandom); m_emax = 16'($urandom); m_emin = 16'($urandom);
            m_ethr = 16'($urandom); m_ch = 16'($urandom); m_ts = 16'($urandom);
            if ($urandom_range(0, 7) == 0) m_hops = 16'hFFFF;
            if (model_legal(m_type, m_role)) begin
                send_and_check($sformatf("rand%0d", k), -1, 35, 1'b1);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end else begin
                check_reject($sformatf("rand%0d", k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hb();
        test_inv();
        test_join_stall();
        test_hops_sat();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
